mc_controller: RTL and testbench

- Multicycle control unit that drives the 32-bit ALU's F (alucontrol) input and the datapath enables and selects, and consumes the ALU's zero flag.
- Moore FSM sequences one MIPS-subset instruction over 3–5 cycles: lw, sw, R-type, beq, addi, j.
- An alu_decoder sub-module maps aluop/funct onto the ALU F encoding.
- Sits between instruction register (op, funct) and datapath.

---
 rtl/mc_controller_pkg.sv | 47 ++++
 rtl/mc_controller_alu_decoder.sv | 29 ++
 rtl/mc_controller.sv | 133 +++++++++++++
 tb/tb_mc_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcodes, R-type function codes, aluop classes and ALU F codes.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } statetype;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // The 100 slot computes A & ~B on this ALU; 011 yields a constant 0.
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_ZERO = 3'b011;
   localparam logic [2:0] ALU_ANDN = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational map from aluop class and R-type funct onto the ALU F code.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               FN_NOR:  alucontrol = ALU_ANDN;
               default: alucontrol = ALU_ZERO;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle datapath; outputs decode the current
// state, with write strobes suppressed and FETCH selects shown during reset.
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
);

   statetype   state_reg, state_next;
   logic       pcwrite, branch;
   logic [1:0] aluop;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= FETCH;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state_reg)
         FETCH:  state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_ADDI:      state_next = ADDIEX;
               OP_J:         state_next = JUMP;
               default:      state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_next = MEMWB;
         EXECUTE: state_next = ALUWB;
         ADDIEX:  state_next = ADDIWB;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = ALUOP_ADD;
      case (state_reg)
         FETCH: begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         DECODE: alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: iord = 1'b1;
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         ADDIWB: regwrite = 1'b1;
         BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      // Reset overrides whatever state is held so an abandoned instruction never writes.
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         iord     = 1'b0;
         memtoreg = 1'b0;
         regdst   = 1'b0;
         alusrca  = 1'b0;
         alusrcb  = 2'b01;
         pcsrc    = 2'b00;
         aluop    = ALUOP_ADD;
      end
      pcen = pcwrite | (branch & zero);
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: an instruction-step model is compared every
// cycle, and hand-computed per-instruction strobe patterns pin the model.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset, zero;
   logic [5:0] op, funct;
   logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   int n_assert = 0;
   int n_fail   = 0;
   int step     = 1;

   logic [4:0] h_pcen, h_ir, h_mw, h_rw, h_mtr, h_rd, h_iord;
   logic [2:0] h_ac [5];
   logic [1:0] h_ps [5];

   always #5 clk = ~clk;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol)
   );

   function automatic int latency(input logic [5:0] o);
      case (o)
         6'b100011:                       return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000010:            return 3;
         default:                         return 2;
      endcase
   endfunction

   function automatic logic [2:0] rtype_f(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b100111: return 3'b100;
         default:   return 3'b011;
      endcase
   endfunction

   // Expected outputs from the instruction type and the cycle number within it.
   function automatic logic [14:0] model(input logic rst, input logic [5:0] o,
                                         input logic [5:0] f, input logic z, input int s);
      logic pe, ir, mw, rw, io, mt, rd, sa;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      pe = 0; ir = 0; mw = 0; rw = 0; io = 0; mt = 0; rd = 0; sa = 0;
      sb = 2'b00; ps = 2'b00; ac = 3'b010;
      if (rst) begin
         sb = 2'b01;
      end else begin
         case (s)
            1: begin ir = 1; pe = 1; sb = 2'b01; end
            2: sb = 2'b11;
            3: begin
               case (o)
                  6'b100011, 6'b101011, 6'b001000: begin sa = 1; sb = 2'b10; end
                  6'b000000: begin sa = 1; ac = rtype_f(f); end
                  6'b000100: begin sa = 1; ps = 2'b01; ac = 3'b110; pe = z; end
                  6'b000010: begin ps = 2'b10; pe = 1; end
                  default: ;
               endcase
            end
            4: begin
               case (o)
                  6'b100011: io = 1;
                  6'b101011: begin io = 1; mw = 1; end
                  6'b000000: begin rw = 1; rd = 1; end
                  6'b001000: rw = 1;
                  default: ;
               endcase
            end
            5: begin rw = 1; mt = 1; end
            default: ;
         endcase
      end
      return {pe, ir, mw, rw, io, mt, rd, sa, sb, ps, ac};
   endfunction

   always @(posedge clk) begin
      if (reset)                    step <= 1;
      else if (step >= latency(op)) step <= 1;
      else                          step <= step + 1;
   end

   always @(negedge clk) begin
      logic [14:0] act, req;
      act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol};
      req = model(reset, op, funct, zero, step);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL cycle_vec t=%0t step=%0d op=%b actual=%b required=%b",
                  $time, step, op, act, req);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Called just after a rising edge; holds op/funct for n cycles, zero from zp.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic [4:0] zp, input int n);
      h_pcen = 0; h_ir = 0; h_mw = 0; h_rw = 0; h_mtr = 0; h_rd = 0; h_iord = 0;
      for (int k = 0; k < 5; k++) begin h_ac[k] = 0; h_ps[k] = 0; end
      for (int k = 0; k < n; k++) begin
         op = o; funct = f; zero = zp[k];
         #3;
         h_pcen[k] = pcen; h_ir[k] = irwrite; h_mw[k] = memwrite; h_rw[k] = regwrite;
         h_mtr[k] = memtoreg; h_rd[k] = regdst; h_iord[k] = iord;
         h_ac[k] = alucontrol; h_ps[k] = pcsrc;
         $display("instr op=%b funct=%b cycle=%0d pcen=%b irwrite=%b memwrite=%b regwrite=%b alucontrol=%b",
                  o, f, k + 1, pcen, irwrite, memwrite, regwrite, alucontrol);
         @(posedge clk); #1;
      end
   endtask

   logic [5:0] fn_tab [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b100111};
   logic [2:0] ac_tab [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};

   initial begin
      reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
      @(posedge clk); #4;
      chk("rst_pcen", pcen, 0);
      chk("rst_irwrite", irwrite, 0);
      chk("rst_alusrcb", alusrcb, 2'b01);
      chk("rst_alucontrol", alucontrol, 3'b010);
      @(posedge clk); #1;
      reset = 1'b0;

      run_instr(6'b100011, 6'b0, 5'b0, 5);
      chk("lw_irwrite", h_ir, 5'b00001);
      chk("lw_regwrite", h_rw, 5'b10000);
      chk("lw_memtoreg", h_mtr, 5'b10000);
      chk("lw_iord", h_iord, 5'b01000);
      chk("lw_pcen", h_pcen, 5'b00001);

      for (int i = 0; i < 7; i++) begin
         run_instr(6'b000000, fn_tab[i], 5'b0, 4);
         chk("rtype_alucontrol", h_ac[2], ac_tab[i]);
         chk("rtype_regdst", h_rd, 5'b01000);
         chk("rtype_regwrite", h_rw, 5'b01000);
      end

      run_instr(6'b000100, 6'b0, 5'b00100, 3);
      chk("beq_taken_pcen", h_pcen, 5'b00101);
      chk("beq_pcsrc", h_ps[2], 2'b01);
      chk("beq_alucontrol", h_ac[2], 3'b110);
      run_instr(6'b000100, 6'b0, 5'b00010, 3);
      chk("beq_nottaken_pcen", h_pcen, 5'b00001);

      run_instr(6'b101011, 6'b0, 5'b0, 4);
      chk("sw_memwrite", h_mw, 5'b01000);
      chk("sw_iord", h_iord, 5'b01000);
      chk("sw_regwrite", h_rw, 5'b00000);

      run_instr(6'b001000, 6'b0, 5'b0, 4);
      chk("addi_regwrite", h_rw, 5'b01000);
      chk("addi_regdst", h_rd, 5'b00000);

      run_instr(6'b000010, 6'b0, 5'b11111, 3);
      chk("j_pcen", h_pcen, 5'b00101);
      chk("j_pcsrc", h_ps[2], 2'b10);

      run_instr(6'b111111, 6'b0, 5'b0, 3);
      chk("illegal_regwrite", h_rw, 5'b00000);
      chk("illegal_memwrite", h_mw, 5'b00000);
      chk("illegal_pcen", h_pcen, 5'b00101);
      chk("illegal_irwrite", h_ir, 5'b00101);

      run_instr(6'b101011, 6'b0, 5'b0, 3);
      reset = 1'b1;
      #3;
      chk("midrst_memwrite", memwrite, 0);
      chk("midrst_iord", iord, 0);
      chk("midrst_pcen", pcen, 0);
      @(posedge clk); #3;
      chk("rsthold_memwrite", memwrite, 0);
      chk("rsthold_irwrite", irwrite, 0);
      chk("rsthold_alusrcb", alusrcb, 2'b01);
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(6'b100011, 6'b0, 5'b0, 5);
      chk("postrst_lw_irwrite", h_ir, 5'b00001);
      chk("postrst_lw_regwrite", h_rw, 5'b10000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
